// File: rtl/front_panel_pkg.sv
// Shared types for the Altair front panel controller.
// State and action enums, switch indices, panel widths.
package front_panel_pkg;

  localparam int PANEL_ADDR_W = 16;
  localparam int PANEL_DATA_W = 8;

  localparam int SW_ON       = 0;
  localparam int SW_RUN      = 1;
  localparam int SW_STEP     = 2;
  localparam int SW_EXAM     = 3;
  localparam int SW_EXAM_NXT = 4;
  localparam int SW_DEP      = 5;
  localparam int SW_DEP_NXT  = 6;
  localparam int SW_RESET    = 7;
  localparam int SW_CLEAR    = 8;
  localparam int SW_PROT     = 9;
  localparam int SW_UNPROT   = 10;
  localparam int NUM_SW      = 11;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    STEP
  } fp_state_t;

  typedef enum logic [3:0] {
    ACT_NONE,
    ACT_RESET,
    ACT_CLEAR,
    ACT_EXAM,
    ACT_EXAM_NXT,
    ACT_DEP,
    ACT_DEP_NXT,
    ACT_STEP,
    ACT_PROT,
    ACT_UNPROT
  } fp_act_t;

  function automatic fp_act_t pick_act(
    input logic [NUM_SW-1:0] ev
  );
    fp_act_t a;
    a = ACT_NONE;
    priority case (1'b1)
      ev[SW_RESET]:    a = ACT_RESET;
      ev[SW_CLEAR]:    a = ACT_CLEAR;
      ev[SW_EXAM]:     a = ACT_EXAM;
      ev[SW_EXAM_NXT]: a = ACT_EXAM_NXT;
      ev[SW_DEP]:      a = ACT_DEP;
      ev[SW_DEP_NXT]:  a = ACT_DEP_NXT;
      ev[SW_STEP]:     a = ACT_STEP;
      ev[SW_PROT]:     a = ACT_PROT;
      ev[SW_UNPROT]:   a = ACT_UNPROT;
      default:         a = ACT_NONE;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/front_panel_controller_if.sv
// Single-outstanding memory request/ack port used by the panel.
// The controller is master; the memory arbiter is slave.
interface fp_mem_if;
  import front_panel_pkg::*;

  logic                    mem_req;
  logic                    mem_we;
  logic [0:PANEL_ADDR_W-1] mem_addr;
  logic [0:PANEL_DATA_W-1] mem_wdata;
  logic                    mem_ack;
  logic [0:PANEL_DATA_W-1] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/fp_switch_debounce.sv
// Two-flop synchroniser plus stability counter for one panel switch.
// rise_o pulses for one cycle when the accepted level goes 0 -> 1.
module fp_switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW =
    (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == LAST) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/front_panel_controller.sv
// Altair front panel: turns debounced operator switches into
// CPU control pulses and panel memory examine/deposit cycles.
module front_panel_controller
  import front_panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ACK_TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       on_off_sw,
  input  logic       stop_run_sw,
  input  logic       step_sw,
  input  logic       examine_sw,
  input  logic       examine_next_sw,
  input  logic       deposit_sw,
  input  logic       deposit_next_sw,
  input  logic       reset_sw,
  input  logic       clear_sw,
  input  logic       protect_sw,
  input  logic       unprotect_sw,
  input  logic [0:7] sense_addr_sw,
  input  logic [0:7] data_addr_sw,
  fp_mem_if.master   mem,
  input  logic       cpu_step_ack,
  output logic       cpu_run,
  output logic       cpu_step,
  output logic       cpu_reset,
  output logic       cpu_clear,
  output logic       cpu_pc_load,
  output logic       prot_set,
  output logic       prot_clr,
  output logic [0:7] prot_page,
  output logic [0:15] panel_addr,
  output logic [0:7] panel_data,
  output logic       busy
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(ACK_TIMEOUT);

  logic [NUM_SW-1:0] sw_raw, lvl, rise, ev;
  logic              off, idle_ok, unused_sw;
  fp_act_t           act;

  assign sw_raw = {
    unprotect_sw, protect_sw, clear_sw, reset_sw,
    deposit_next_sw, deposit_sw, examine_next_sw,
    examine_sw, step_sw, stop_run_sw, on_off_sw
  };

  for (genvar i = 0; i < NUM_SW; i++) begin : g_db
    fp_switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .sw_i    (sw_raw[i]),
      .level_o (lvl[i]),
      .rise_o  (rise[i])
    );
  end

  assign unused_sw = ^{lvl[NUM_SW-1:SW_STEP], rise[SW_RUN:SW_ON]};

  fp_state_t               state_q, state_d;
  logic [0:PANEL_ADDR_W-1] panel_addr_q, panel_addr_d, addr_inc;
  logic [0:PANEL_DATA_W-1] panel_data_q, panel_data_d;
  logic [0:PANEL_ADDR_W-1] mem_addr_q, mem_addr_d;
  logic [0:PANEL_DATA_W-1] mem_wdata_q, mem_wdata_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic                    cpu_run_q, cpu_run_d;
  logic                    cpu_step_q, cpu_step_d;
  logic                    cpu_reset_q, cpu_reset_d;
  logic                    cpu_clear_q, cpu_clear_d;
  logic                    cpu_pc_load_q, cpu_pc_load_d;
  logic                    prot_set_q, prot_set_d;
  logic                    prot_clr_q, prot_clr_d;

  assign off     = lvl[SW_ON];
  assign idle_ok = (state_q == IDLE) && !cpu_run_q && !off;

  // reset/clear bypass the IDLE/stopped gate; gated events are dropped
  always_comb begin
    ev            = rise & {NUM_SW{idle_ok}};
    ev[SW_ON]     = 1'b0;
    ev[SW_RUN]    = 1'b0;
    ev[SW_RESET]  = rise[SW_RESET] && !off;
    ev[SW_CLEAR]  = rise[SW_CLEAR] && !off;
  end

  assign act      = pick_act(ev);
  assign addr_inc = panel_addr_q + 16'd1;

  always_comb begin
    state_d       = state_q;
    panel_addr_d  = panel_addr_q;
    panel_data_d  = panel_data_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_req_d     = mem_req_q;
    tmo_d         = tmo_q;
    cpu_step_d    = 1'b0;
    cpu_reset_d   = 1'b0;
    cpu_clear_d   = 1'b0;
    cpu_pc_load_d = 1'b0;
    prot_set_d    = 1'b0;
    prot_clr_d    = 1'b0;

    if (state_q != IDLE) begin
      tmo_d = tmo_q + TW'(1);
      case (state_q)
        RD, WR: begin
          if (mem_req_q && mem.mem_ack) begin
            panel_data_d = (state_q == RD) ?
              mem.mem_rdata : mem_wdata_q;
            mem_req_d = 1'b0;
            state_d   = IDLE;
          end else begin
            mem_req_d = 1'b1;
          end
        end
        STEP: if (cpu_step_ack) state_d = IDLE;
        default: ;
      endcase
      if (state_d != IDLE && tmo_q == TMO_MAX) begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    end

    if (off) begin
      state_d   = IDLE;
      mem_req_d = 1'b0;
    end

    unique case (act)
      ACT_RESET: begin
        cpu_reset_d  = 1'b1;
        panel_addr_d = '0;
        state_d      = IDLE;
        mem_req_d    = 1'b0;
      end
      ACT_CLEAR: cpu_clear_d = 1'b1;
      ACT_EXAM, ACT_EXAM_NXT: begin
        panel_addr_d = (act == ACT_EXAM) ?
          {sense_addr_sw, data_addr_sw} : addr_inc;
        mem_addr_d    = panel_addr_d;
        cpu_pc_load_d = 1'b1;
        state_d       = RD;
        mem_req_d     = 1'b0;
        tmo_d         = '0;
      end
      ACT_DEP, ACT_DEP_NXT: begin
        if (act == ACT_DEP_NXT) panel_addr_d = addr_inc;
        mem_addr_d  = panel_addr_d;
        mem_wdata_d = data_addr_sw;
        state_d     = WR;
        mem_req_d   = 1'b0;
        tmo_d       = '0;
      end
      ACT_STEP: begin
        cpu_step_d = 1'b1;
        state_d    = STEP;
        tmo_d      = '0;
      end
      ACT_PROT:   prot_set_d = 1'b1;
      ACT_UNPROT: prot_clr_d = 1'b1;
      default: ;
    endcase

    mem_we_d  = mem_req_d && (state_d == WR);
    cpu_run_d = lvl[SW_RUN] && !off && (state_d != STEP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      panel_addr_q  <= '0;
      panel_data_q  <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      tmo_q         <= '0;
      cpu_run_q     <= 1'b0;
      cpu_step_q    <= 1'b0;
      cpu_reset_q   <= 1'b0;
      cpu_clear_q   <= 1'b0;
      cpu_pc_load_q <= 1'b0;
      prot_set_q    <= 1'b0;
      prot_clr_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      panel_addr_q  <= panel_addr_d;
      panel_data_q  <= panel_data_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      tmo_q         <= tmo_d;
      cpu_run_q     <= cpu_run_d;
      cpu_step_q    <= cpu_step_d;
      cpu_reset_q   <= cpu_reset_d;
      cpu_clear_q   <= cpu_clear_d;
      cpu_pc_load_q <= cpu_pc_load_d;
      prot_set_q    <= prot_set_d;
      prot_clr_q    <= prot_clr_d;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign cpu_run       = cpu_run_q;
  assign cpu_step      = cpu_step_q;
  assign cpu_reset     = cpu_reset_q;
  assign cpu_clear     = cpu_clear_q;
  assign cpu_pc_load   = cpu_pc_load_q;
  assign prot_set      = prot_set_q;
  assign prot_clr      = prot_clr_q;
  assign prot_page     = panel_addr_q[0:7];
  assign panel_addr    = panel_addr_q;
  assign panel_data    = panel_data_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: doc/front_panel_controller.md
Name: front_panel_controller

Overview:
- Consumes the decoded Altair front-panel switch levels and turns operator actions into machine operations:
  - run/stop and single step;
  - examine, examine next, deposit and deposit next, carried out over a single-outstanding memory request/ack port;
  - reset, clear, protect and unprotect.
- Sits between the front-panel switch decoder and the 8080 core / memory arbiter.
- Holds the panel address and data registers that feed the address and data LEDs while the CPU is stopped.

Parameters:
DEBOUNCE_CYCLES, 16, clock cycles a switch level must stay stable before it is accepted (minimum 1)
ACK_TIMEOUT, 255, maximum wait cycles for mem_ack or cpu_step_ack before the operation is abandoned

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
on_off_sw  in  1  1 = panel off: all actions blocked, cpu_run forced to 0
stop_run_sw  in  1  level; 1 = run requested
step_sw, examine_sw, examine_next_sw, deposit_sw, deposit_next_sw, reset_sw, clear_sw, protect_sw, unprotect_sw  in  1 each  momentary switch levels
sense_addr_sw  in  [0:7]  A15..A8 (index 0 = MSB)
data_addr_sw  in  [0:7]  A7..A0 and D7..D0 (index 0 = MSB)
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write, 0 = read; valid while mem_req = 1
mem_addr  out  [0:15]  request address
mem_wdata  out  [0:7]  write data
mem_ack  in  1  one-cycle completion strobe
mem_rdata  in  [0:7]  read data, valid with mem_ack
cpu_run  out  1  CPU free-run enable
cpu_step  out  1  one-cycle pulse: execute one instruction
cpu_step_ack  in  1  instruction complete
cpu_reset  out  1  one-cycle pulse: PC <= 0
cpu_clear  out  1  one-cycle pulse: I/O clear
cpu_pc_load  out  1  one-cycle pulse: PC <= panel_addr
prot_set, prot_clr  out  1 each  one-cycle pulses; the page is prot_page
prot_page  out  [0:7]  panel_addr[0:7]
panel_addr  out  [0:15]  panel address register, drives the LED mux
panel_data  out  [0:7]  last data read or written
busy  out  1  state machine not in IDLE

Behaviour:
- Reset values: every output is 0; panel_addr = 0000h, panel_data = 00h; state = IDLE; debouncers hold value 0.
- Debounce (each of the 11 switch inputs):
  - 2-FF synchroniser, then a counter.
  - The accepted level changes only after the input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Every momentary switch generates a one-cycle rise event.
- cpu_run:
  - Registered; equals debounced stop_run_sw AND NOT on_off_sw.
  - Forced to 0 while stepping.
- Action gating:
  - Actions other than reset/clear are accepted only in IDLE with cpu_run = 0 and on_off_sw = 0.
  - Reset/clear are accepted in any state while on_off_sw = 0.
  - Events that arrive while gated are dropped, not queued.
- Same-cycle priority: reset > clear > examine > examine_next > deposit > deposit_next > step > protect > unprotect. Only the highest-priority event acts.
- reset: pulses cpu_reset, sets panel_addr = 0, aborts any pending operation (mem_req drops the next cycle), returns to IDLE.
- clear: pulses cpu_clear only; state is unchanged.
- examine:
  - panel_addr <= {sense_addr_sw, data_addr_sw}; pulse cpu_pc_load; go to RD.
- examine_next: panel_addr <= panel_addr + 1, wrapping FFFFh -> 0000h; pulse cpu_pc_load; go to RD.
- deposit: go to WR with mem_addr = panel_addr and mem_wdata = data_addr_sw.
- deposit_next: panel_addr += 1 (wrapping), then WR at the new address.
- step: pulse cpu_step; go to STEP.
- protect / unprotect: pulse prot_set or prot_clr for 1 cycle; state stays IDLE.
- States: IDLE, RD, WR, STEP.
- RD / WR:
  - mem_req = 1 from the cycle after entry; mem_we = 1 in WR only.
  - mem_addr and mem_wdata are stable for the whole request.
  - On mem_ack:
    - RD: panel_data <= mem_rdata.
    - WR: panel_data <= mem_wdata.
    - In both cases mem_req drops in the same registered update and the state returns to IDLE.
  - mem_ack while mem_req = 0 is ignored.
- STEP:
  - Wait for cpu_step_ack, then return to IDLE.
  - panel_addr is not modified; the LED mux shows the CPU bus.
- Timeout: a counter runs in RD, WR and STEP. On reaching ACK_TIMEOUT the FSM returns to IDLE, mem_req drops, and panel_data is unchanged.
- on_off_sw rising to 1 mid-operation: treated as an abort. mem_req drops, state goes to IDLE, cpu_run = 0; panel registers are kept.
- Asynchronous reset mid-operation: all outputs return to their reset values immediately.

Decomposition:
- Package front_panel_pkg:
  - state enum fp_state_t {IDLE, RD, WR, STEP};
  - action priority enum;
  - constants PANEL_ADDR_W = 16, PANEL_DATA_W = 8.
- Sub-module fp_switch_debounce, instantiated once per switch. It contains the synchroniser, the DEBOUNCE_CYCLES counter and a rise-pulse output.

Test Plan:
- Reset and defaults: reset_n low then released, all switches 0 -> all outputs 0, panel_addr = 0000h, busy = 0.
- Examine: sense = 12h, data = 34h, examine held > DEBOUNCE_CYCLES, ack after 3 cycles with rdata = A5h -> cpu_pc_load pulse, mem_req high 3 cycles with mem_addr = 1234h and mem_we = 0, panel_data = A5h.
- Deposit next with wrap: panel_addr = FFFFh, data_addr_sw = 5Ah, deposit_next -> mem_addr = 0000h, mem_we = 1, mem_wdata = 5Ah, panel_addr = 0000h.
- Priority and gating: examine and deposit rise in the same cycle -> only a read is issued. Examine while stop_run_sw = 1 -> no mem_req.
- Abort paths:
  - reset_sw during a pending read (no ack) -> cpu_reset pulse, mem_req drops the next cycle, panel_addr = 0.
  - No ack for ACK_TIMEOUT cycles -> return to IDLE, panel_data unchanged.
- Bounce and step: examine toggled every 3 cycles with DEBOUNCE_CYCLES = 16 -> no action. Single step -> one cpu_step pulse, busy until cpu_step_ack.
